// File: rtl/instr_register_exec.sv
// rtl/instr_register_exec.sv - instruction register with integrated 64-bit ALU and sequential divider
// instruction_word packs {opc[2:0], op_a[31:0], op_b[31:0], result[63:0]}.
module instr_register_exec #(
  parameter int DEPTH    = 32,
  parameter int DIV_ITER = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_en,
  input  logic [31:0]  operand_a,
  input  logic [31:0]  operand_b,
  input  logic [2:0]   opcode,
  input  logic [4:0]   write_pointer,
  input  logic [4:0]   read_pointer,
  output logic [130:0] instruction_word,
  output logic         rd_valid,
  output logic         busy
);
  localparam logic [2:0] OP_ZERO = 3'd0, OP_PASSA = 3'd1, OP_PASSB = 3'd2, OP_ADD = 3'd3,
                         OP_SUB = 3'd4, OP_MULT = 3'd5, OP_DIV = 3'd6, OP_MOD = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  logic [2:0]       opc_q     [DEPTH];
  logic [31:0]      op_a_q    [DEPTH];
  logic [31:0]      op_b_q    [DEPTH];
  logic [63:0]      res_q     [DEPTH];
  logic [DEPTH-1:0] written_q;
  logic [DEPTH-1:0] pending_q;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [4:0]  div_addr_q;
  logic        is_mod_q, sa_q, sb_q;
  logic [31:0] dvd_q, dvs_q;
  logic [32:0] rem_q;

  logic        accept, div_start, ge;
  logic [63:0] a64, b64, res_d, q64, r64, res_fix;
  logic [31:0] abs_a, abs_b;
  logic [32:0] rem_shift;

  always_comb begin
    a64       = {{32{operand_a[31]}}, operand_a};
    b64       = {{32{operand_b[31]}}, operand_b};
    accept    = load_en && !busy;
    div_start = accept && (opcode == OP_DIV || opcode == OP_MOD) && (operand_b != 32'd0);
    abs_a     = operand_a[31] ? -operand_a : operand_a;
    abs_b     = operand_b[31] ? -operand_b : operand_b;
    res_d     = 64'd0;
    case (opcode)
      OP_PASSA: res_d = a64;
      OP_PASSB: res_d = b64;
      OP_ADD:   res_d = a64 + b64;
      OP_SUB:   res_d = a64 - b64;
      OP_MULT:  res_d = a64 * b64;
      default:  res_d = 64'd0;
    endcase
    // One restoring step: shift next dividend bit into the partial remainder.
    rem_shift = {rem_q[31:0], dvd_q[31]};
    ge        = rem_shift >= {1'b0, dvs_q};
    q64       = {32'd0, dvd_q};
    r64       = {31'd0, rem_q};
    if (is_mod_q) res_fix = sa_q ? -r64 : r64;
    else          res_fix = (sa_q ^ sb_q) ? -q64 : q64;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        opc_q[i]  <= OP_ZERO;
        op_a_q[i] <= 32'd0;
        op_b_q[i] <= 32'd0;
        res_q[i]  <= 64'd0;
      end
      written_q        <= '0;
      pending_q        <= '0;
      state_q          <= S_IDLE;
      cnt_q            <= 5'd0;
      div_addr_q       <= 5'd0;
      is_mod_q         <= 1'b0;
      sa_q             <= 1'b0;
      sb_q             <= 1'b0;
      dvd_q            <= 32'd0;
      dvs_q            <= 32'd0;
      rem_q            <= 33'd0;
      busy             <= 1'b0;
      instruction_word <= '0;
      rd_valid         <= 1'b0;
    end else begin
      instruction_word <= {opc_q[read_pointer], op_a_q[read_pointer],
                           op_b_q[read_pointer], res_q[read_pointer]};
      rd_valid         <= written_q[read_pointer] & ~pending_q[read_pointer];

      if (accept) begin
        opc_q[write_pointer]     <= opcode;
        op_a_q[write_pointer]    <= operand_a;
        op_b_q[write_pointer]    <= operand_b;
        res_q[write_pointer]     <= div_start ? 64'd0 : res_d;
        written_q[write_pointer] <= 1'b1;
        pending_q[write_pointer] <= div_start;
      end

      case (state_q)
        S_IDLE: begin
          if (div_start) begin
            state_q    <= S_CALC;
            busy       <= 1'b1;
            cnt_q      <= 5'd0;
            div_addr_q <= write_pointer;
            is_mod_q   <= (opcode == OP_MOD);
            sa_q       <= operand_a[31];
            sb_q       <= operand_b[31];
            dvd_q      <= abs_a;
            dvs_q      <= abs_b;
            rem_q      <= 33'd0;
          end
        end
        S_CALC: begin
          rem_q <= ge ? rem_shift - {1'b0, dvs_q} : rem_shift;
          dvd_q <= {dvd_q[30:0], ge};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_ITER - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          res_q[div_addr_q]     <= res_fix;
          pending_q[div_addr_q] <= 1'b0;
          busy                  <= 1'b0;
          state_q               <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_register_exec.sv
// tb/tb_instr_register_exec.sv - directed self-checking bench for instr_register_exec
module tb_instr_register_exec;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         load_en;
  logic [31:0]  operand_a, operand_b;
  logic [2:0]   opcode;
  logic [4:0]   write_pointer, read_pointer;
  logic [130:0] instruction_word;
  logic         rd_valid, busy;

  int checks = 0;
  int errors = 0;
  int n;

  instr_register_exec dut (
    .clk(clk), .reset_n(reset_n), .load_en(load_en),
    .operand_a(operand_a), .operand_b(operand_b), .opcode(opcode),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .instruction_word(instruction_word), .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [130:0] got, input logic [130:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [130:0] mk(input logic [2:0] o, input logic [31:0] a,
                                      input logic [31:0] b, input logic [63:0] r);
    return {o, a, b, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] addr);
    opcode = o; operand_a = a; operand_b = b; write_pointer = addr; load_en = 1'b1;
    step();
    load_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] addr);
    read_pointer = addr;
    step();
  endtask

  task automatic wait_idle();
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
    check("idle_timeout", {130'd0, busy}, 131'd0);
  endtask

  initial begin
    reset_n = 1'b0; load_en = 1'b0; operand_a = '0; operand_b = '0;
    opcode = 3'd0; write_pointer = '0; read_pointer = '0;
    step(); step();
    check("rst_word", instruction_word, '0);
    check("rst_valid", {130'd0, rd_valid}, 131'd0);
    check("rst_busy", {130'd0, busy}, 131'd0);
    reset_n = 1'b1;

    wr(3'd3, 32'd5, 32'd3, 5'd0);
    rd(5'd0);
    check("add_word", instruction_word, mk(3'd3, 32'd5, 32'd3, 64'd8));
    check("add_valid", {130'd0, rd_valid}, 131'd1);

    wr(3'd4, -32'sd7, 32'd9, 5'd1);
    wr(3'd5, -32'sd15, 32'd15, 5'd2);
    rd(5'd1);
    check("sub_word", instruction_word, mk(3'd4, -32'sd7, 32'd9, -64'sd16));
    rd(5'd2);
    check("mult_word", instruction_word, mk(3'd5, -32'sd15, 32'd15, -64'sd225));
    rd(5'd31);
    check("unwr_word", instruction_word, '0);
    check("unwr_valid", {130'd0, rd_valid}, 131'd0);

    // DIV -15/4: count busy cycles while hammering a refused MOD write at addr 4
    wr(3'd6, -32'sd15, 32'd4, 5'd3);
    opcode = 3'd7; operand_a = 32'd1; operand_b = 32'd1; write_pointer = 5'd4;
    load_en = 1'b1; read_pointer = 5'd3;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 2) begin
        check("pend_word", instruction_word, mk(3'd6, -32'sd15, 32'd4, 64'd0));
        check("pend_valid", {130'd0, rd_valid}, 131'd0);
      end
      step();
    end
    load_en = 1'b0;
    check("busy_cycles", 131'(n), 131'd33);
    rd(5'd3);
    check("div_word", instruction_word, mk(3'd6, -32'sd15, 32'd4, -64'sd3));
    check("div_valid", {130'd0, rd_valid}, 131'd1);
    rd(5'd4);
    check("refused_word", instruction_word, '0);
    check("refused_valid", {130'd0, rd_valid}, 131'd0);

    wr(3'd7, -32'sd15, 32'd4, 5'd4);
    wait_idle();
    rd(5'd4);
    check("mod_neg", instruction_word, mk(3'd7, -32'sd15, 32'd4, -64'sd3));
    wr(3'd7, 32'd15, -32'sd4, 5'd4);
    wait_idle();
    rd(5'd4);
    check("mod_pos", instruction_word, mk(3'd7, 32'd15, -32'sd4, 64'd3));

    wr(3'd6, 32'd7, 32'd0, 5'd7);
    check("div0_busy", {130'd0, busy}, 131'd0);
    wr(3'd7, 32'd7, 32'd0, 5'd8);
    check("mod0_busy", {130'd0, busy}, 131'd0);
    rd(5'd7);
    check("div0_word", instruction_word, mk(3'd6, 32'd7, 32'd0, 64'd0));
    check("div0_valid", {130'd0, rd_valid}, 131'd1);
    rd(5'd8);
    check("mod0_word", instruction_word, mk(3'd7, 32'd7, 32'd0, 64'd0));

    wr(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    wait_idle();
    rd(5'd10);
    check("div_min", instruction_word, mk(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000));

    // Abort an in-flight division with reset
    wr(3'd6, 32'd14, 32'd3, 5'd5);
    read_pointer = 5'd5;
    for (int i = 0; i < 9; i++) step();
    check("abort_busy_pre", {130'd0, busy}, 131'd1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {130'd0, busy}, 131'd0);
    check("abort_word", instruction_word, '0);
    step();
    reset_n = 1'b1;
    rd(5'd5);
    check("abort_entry", instruction_word, '0);
    check("abort_valid", {130'd0, rd_valid}, 131'd0);
    wr(3'd2, 32'd9, 32'd10, 5'd9);
    rd(5'd9);
    check("post_rst_word", instruction_word, mk(3'd2, 32'd9, 32'd10, 64'd10));
    check("post_rst_valid", {130'd0, rd_valid}, 131'd1);

    // Read-before-write at the same edge and address
    read_pointer = 5'd6;
    wr(3'd1, 32'hFFFF_FFFF, 32'd2, 5'd6);
    check("rbw_old", instruction_word, '0);
    check("rbw_old_valid", {130'd0, rd_valid}, 131'd0);
    step();
    check("rbw_new", instruction_word, mk(3'd1, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF));
    check("rbw_new_valid", {130'd0, rd_valid}, 131'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
